seq_detect_arbiter: RTL and testbench

//  Shares one serial pattern-detector FSM among NUM_REQ requesters.

---
 rtl/seq_arb_pkg.sv | 16 +
 rtl/seq_detect_core.sv | 34 +++
 rtl/seq_detect_arbiter.sv | 156 +++++++++++++++
 tb/tb_seq_detect_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arb_pkg.sv
// rtl/seq_arb_pkg.sv - shared controller state encoding and sizing helpers for seq_detect_arbiter
package seq_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_GRANT  = 3'b001,
        ST_SHIFT  = 3'b010,
        ST_REPORT = 3'b011
    } state_t;

    // Wide enough to count every bit of one job word
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_core.sv
// rtl/seq_detect_core.sv - serial pattern detector with per-job history clear
module seq_detect_core #(
    parameter int                PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PATTERN = 3'b110
) (
    input  logic clk,
    input  logic clear_n,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_valid,
    output logic match
);

    localparam int HW = PAT_W - 1;

    logic [HW-1:0]    hist;
    logic [HW-1:0]    fill;
    logic [PAT_W-1:0] window;

    assign window = {hist, bit_in};
    // fill guards against zero-initialised history faking a match before PAT_W bits arrive
    assign match  = bit_valid && (&fill) && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (!clear_n || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_valid) begin
            hist <= window[HW-1:0];
            fill <= (fill << 1) | HW'(1);
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - arbitrates NUM_REQ jobs onto one serial pattern detector
// SEQ_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module seq_detect_arbiter
    import seq_arb_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               DATA_W  = 8,
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 4
) (
    input  logic                       clk_pulse,
    input  logic                       clear_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       ser_bit,
    output logic                       ser_valid,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [2:0]                 present_state
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam int              BC_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state, state_nx;
    logic [NUM_REQ-1:0]  req_q;
    logic [ID_W-1:0]     win, win_q;
    logic [DATA_W-1:0]   words [NUM_REQ];
    logic [DATA_W-1:0]   sreg;
    logic [BC_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]    job_cnt, job_cnt_nx;
    logic                match;
    logic                last_bit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef SEQ_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_q[i]) win = ID_W'(i);
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps, so the last winner is visited last
    always_comb begin
        logic [ID_W:0] idx;
        logic          found;
        win   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && req_q[idx[ID_W-1:0]]) begin
                win   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pulse) begin
        if (!clear_n) begin
            rr_ptr <= '0;
        end else if (state == ST_GRANT) begin
            rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`endif

    assign last_bit   = (bit_cnt == BC_W'(DATA_W - 1));
    assign job_cnt_nx = (match && (job_cnt != CNT_MAX)) ? job_cnt + CNT_W'(1) : job_cnt;

    always_ff @(posedge clk_pulse) begin
        if (!clear_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        gnt      = '0;
        case (state)
            ST_IDLE:   state_nx = (|req) ? ST_GRANT : ST_IDLE;
            ST_GRANT: begin
                gnt[win] = 1'b1;
                state_nx = ST_SHIFT;
            end
            ST_SHIFT:  state_nx = last_bit ? ST_REPORT : ST_SHIFT;
            ST_REPORT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pulse) begin
        if (!clear_n) begin
            req_q     <= '0;
            win_q     <= '0;
            sreg      <= '0;
            bit_cnt   <= '0;
            job_cnt   <= '0;
            done_id   <= '0;
            match_cnt <= '0;
        end else begin
            if (state == ST_IDLE) req_q <= req;
            case (state)
                ST_GRANT: begin
                    sreg    <= words[win];
                    win_q   <= win;
                    bit_cnt <= '0;
                    job_cnt <= '0;
                end
                ST_SHIFT: begin
                    sreg    <= {sreg[DATA_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BC_W'(1);
                    job_cnt <= job_cnt_nx;
                    // Result registers move only as REPORT begins, holding between jobs
                    if (last_bit) begin
                        done_id   <= win_q;
                        match_cnt <= job_cnt_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_detect_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk       (clk_pulse),
        .clear_n   (clear_n),
        .clr       (state == ST_GRANT),
        .bit_in    (sreg[DATA_W-1]),
        .bit_valid (state == ST_SHIFT),
        .match     (match)
    );

    assign busy          = (state != ST_IDLE);
    assign ser_valid     = (state == ST_SHIFT);
    assign ser_bit       = ser_valid & sreg[DATA_W-1];
    assign done          = (state == ST_REPORT);
    assign present_state = state;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb/tb_seq_detect_arbiter.sv - randomized self-checking bench for seq_detect_arbiter
module tb_seq_detect_arbiter;

    localparam int         N   = 4;
    localparam int         DW  = 8;
    localparam int         PW  = 3;
    localparam logic [2:0] PAT = 3'b110;

    logic            clk_pulse = 1'b0;
    logic            clear_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt, gnt_s;
    logic            busy, busy_s, ser_bit, ser_bit_s, ser_valid, ser_valid_s, done, done_s;
    logic [1:0]      done_id, done_id_s;
    logic [3:0]      match_cnt;
    logic [0:0]      match_cnt_s;
    logic [2:0]      present_state, present_state_s;

    int              checks = 0;
    int              errors = 0;
    logic [N-1:0]    req_v;
    logic [DW-1:0]   data_arr [N];
    int              rr_ptr_m;
    int              keep_mode;
    int              w;

    seq_detect_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PAT_W(PW), .PATTERN(PAT), .CNT_W(4)) dut (
        .clk_pulse(clk_pulse), .clear_n(clear_n), .req(req), .req_data(req_data),
        .gnt(gnt), .busy(busy), .ser_bit(ser_bit), .ser_valid(ser_valid), .done(done),
        .done_id(done_id), .match_cnt(match_cnt), .present_state(present_state));

    seq_detect_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PAT_W(PW), .PATTERN(PAT), .CNT_W(1)) dut_sat (
        .clk_pulse(clk_pulse), .clear_n(clear_n), .req(req), .req_data(req_data),
        .gnt(gnt_s), .busy(busy_s), .ser_bit(ser_bit_s), .ser_valid(ser_valid_s), .done(done_s),
        .done_id(done_id_s), .match_cnt(match_cnt_s), .present_state(present_state_s));

    always #5 clk_pulse = ~clk_pulse;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = data_arr[i];
        req = req_v;
    endtask

    // Matches counted over the bit stream in arrival order (MSB first)
    function automatic int count_matches(input logic [DW-1:0] word);
        int c = 0;
        for (int i = PW - 1; i < DW; i++) begin
            bit ok = 1'b1;
            for (int j = 0; j < PW; j++)
                if (word[DW-1-(i-PW+1+j)] != PAT[PW-1-j]) ok = 1'b0;
            if (ok) c++;
        end
        return c;
    endfunction

    function automatic int pick(input logic [N-1:0] pend, input int ptr);
`ifdef SEQ_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
        for (int i = 0; i < N; i++) if (pend[(ptr + i) % N]) return (ptr + i) % N;
`endif
        return 0;
    endfunction

    task automatic do_reset(input int cycles);
        clear_n  = 1'b0;
        rr_ptr_m = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_pulse);
            check("rst_gnt", gnt, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_state", present_state, 0);
            check("rst_cnt", match_cnt, 0);
        end
        clear_n = 1'b1;
    endtask

    // Entered at a falling edge with the DUT idle and req already driven
    task automatic run_job(output int won);
        int            k = 0;
        int            c;
        bit            keep;
        logic [DW-1:0] word;
        do begin
            @(negedge clk_pulse);
            k++;
        end while (gnt == 0 && k < 4);
        check("gnt_latency", k, 1);
        if (gnt == 0) begin
            won = -1;
            return;
        end
        won = pick(req_v, rr_ptr_m);
        check("gnt", gnt, 32'd1 << won);
        check("gnt_sat", gnt_s, 32'd1 << won);
        check("state_grant", present_state, 1);
        word = data_arr[won];
        c    = count_matches(word);
        rr_ptr_m = (won + 1) % N;
        keep = (keep_mode == 1) || (keep_mode == 2 && $urandom_range(0, 3) == 0);
        if (!keep) begin
            req_v[won] = 1'b0;
            drive();
        end
        for (int s = 0; s < DW; s++) begin
            @(negedge clk_pulse);
            check("ser_valid", ser_valid, 1);
            check("ser_bit", ser_bit, word[DW-1-s]);
            check("done_early", done, 0);
            if (s == 0 && !keep) begin
                data_arr[won] = DW'($urandom);
                drive();
            end
        end
        @(negedge clk_pulse);
        check("done", done, 1);
        check("done_id", done_id, won);
        check("match_cnt", match_cnt, (c > 15) ? 15 : c);
        check("done_sat", done_s, 1);
        check("match_cnt_sat", match_cnt_s, (c > 1) ? 1 : c);
        @(negedge clk_pulse);
        check("idle_after", present_state, 0);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int exp_order [4];
        clear_n = 1'b0;
        req_v   = '1;
        for (int i = 0; i < N; i++) data_arr[i] = '0;
        drive();

        do_reset(3);
        clear_n = 1'b0;
        req_v   = '0;
        drive();
        @(negedge clk_pulse);
        clear_n = 1'b1;

        keep_mode   = 0;
        data_arr[2] = 8'b11011011;
        req_v       = 4'b0100;
        drive();
        run_job(w);
        check("single_id", w, 2);

`ifdef SEQ_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 3, 0};
`endif
        do_reset(1);
        keep_mode = 1;
        for (int i = 0; i < N; i++) data_arr[i] = DW'($urandom);
        req_v = 4'b1011;
        drive();
        for (int j = 0; j < 4; j++) begin
            run_job(w);
            check("contention_order", w, exp_order[j]);
        end

        do_reset(1);
        keep_mode   = 0;
        data_arr[0] = 8'b00000011;
        data_arr[1] = 8'b01111111;
        req_v       = 4'b0011;
        drive();
        run_job(w);
        run_job(w);
        data_arr[3] = 8'hFF;
        req_v       = 4'b1000;
        drive();
        run_job(w);

        do_reset(1);
        data_arr[1] = DW'($urandom);
        req_v       = 4'b0010;
        drive();
        @(negedge clk_pulse);
        check("abort_gnt", gnt, 4'b0010);
        req_v = '0;
        drive();
        repeat (4) @(negedge clk_pulse);
        clear_n  = 1'b0;
        rr_ptr_m = 0;
        @(negedge clk_pulse);
        clear_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", done, 0);
            @(negedge clk_pulse);
        end
        for (int i = 0; i < N; i++) data_arr[i] = DW'($urandom);
        req_v = 4'b1011;
        drive();
        run_job(w);
        check("abort_rr_restart", w, 0);

        keep_mode = 2;
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] add = N'($urandom);
            if ((req_v | add) == 0) add[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++)
                if (add[i] && !req_v[i]) data_arr[i] = DW'($urandom);
            req_v = req_v | add;
            drive();
            run_job(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
